// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and FSM state type for the register-file write-port controller.
package regfile_ctrl_pkg;

  localparam int unsigned XLEN_C   = 32;
  localparam int unsigned AW_C     = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ARB,
    ST_CLEAR
  } rfarb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after ptr (mod N) wins.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  int w_best;
  int w_dist;

  // Lowest rotational distance from ptr wins.
  always_comb begin
    w_best  = int'(N);
    w_dist  = 0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      w_dist = (i + int'(N) - int'(ptr)) % int'(N);
      if (req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        gnt_idx = PW'(i);
        any     = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      gnt[i] = any && (gnt_idx == PW'(i));
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single owner of the register-file write port: round-robin writeback arbitration plus a
// zero-fill sweep of x1..x31. Define RFARB_FWD_EN to add the write-forwarding compare ports.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = XLEN_C,
  parameter int unsigned AW   = AW_C
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clear_req,
  output logic                 busy,
`ifdef RFARB_FWD_EN
  input  logic [AW-1:0]        fwd_a1,
  input  logic [AW-1:0]        fwd_a2,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
  output logic [XLEN-1:0]      fwd_data,
`endif
  output logic [AW-1:0]        rf_a3,
  output logic [XLEN-1:0]      rf_wd3,
  output logic                 rf_we3
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(NUM_REGS - 1);

  rfarb_state_t    r_state, w_state_d;
  logic [AW-1:0]   r_idx, w_idx_d;
  logic [AW-1:0]   r_a3, w_a3_d;
  logic [XLEN-1:0] r_wd3, w_wd3_d;
  logic            r_we3, w_we3_d;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_d;

  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_gnt_idx;
  logic            w_any;
  logic [AW-1:0]   w_win_addr;
  logic [XLEN-1:0] w_win_data;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (r_rr_ptr),
    .gnt    (w_gnt),
    .gnt_idx(w_gnt_idx),
    .any    (w_any)
  );

  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_gnt[i]) begin
        w_win_addr = req_addr[i*AW +: AW];
        w_win_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // A clear request pre-empts every requester in the cycle it is seen.
  assign req_ready = ((r_state == ST_ARB) && !clear_req) ? w_gnt : '0;
  assign busy      = (r_state != ST_ARB);

  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_a3_d     = r_a3;
    w_wd3_d    = r_wd3;
    w_we3_d    = 1'b0;
    w_rr_ptr_d = r_rr_ptr;
    unique case (r_state)
      ST_INIT, ST_CLEAR: begin
        w_a3_d  = r_idx;
        w_wd3_d = '0;
        w_we3_d = 1'b1;
        if (r_idx == LastIdx) begin
          w_state_d = ST_ARB;
          w_idx_d   = AW'(1);
        end else begin
          w_idx_d = r_idx + 1'b1;
        end
      end
      ST_ARB: begin
        if (clear_req) begin
          w_state_d = ST_CLEAR;
        end else if (w_any) begin
          w_a3_d     = w_win_addr;
          w_wd3_d    = w_win_data;
          w_we3_d    = (w_win_addr != '0);
          w_rr_ptr_d = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
      end
      default: w_state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_INIT;
      r_idx    <= AW'(1);
      r_a3     <= '0;
      r_wd3    <= '0;
      r_we3    <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_d;
      r_idx    <= w_idx_d;
      r_a3     <= w_a3_d;
      r_wd3    <= w_wd3_d;
      r_we3    <= w_we3_d;
      r_rr_ptr <= w_rr_ptr_d;
    end
  end

  assign rf_a3  = r_a3;
  assign rf_wd3 = r_wd3;
  assign rf_we3 = r_we3;

`ifdef RFARB_FWD_EN
  assign fwd_hit1 = r_we3 && (r_a3 == fwd_a1) && (fwd_a1 != '0);
  assign fwd_hit2 = r_we3 && (r_a3 == fwd_a2) && (fwd_a2 != '0);
  assign fwd_data = r_wd3;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, hand sequences, randomized model run.
module tb_regfile_wb_arbiter;

  localparam logic [31:0] DA = 32'h0000_000A;
  localparam logic [31:0] DB = 32'h0000_000B;
  localparam logic [31:0] DC = 32'h0000_000C;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        clear_req;
  logic        busy;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        rf_we3;
`ifdef RFARB_FWD_EN
  logic [4:0]  fwd_a1;
  logic [4:0]  fwd_a2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data;
`endif

  int n_total = 0;
  int n_pass  = 0;

  regfile_wb_arbiter #(
    .NREQ(3),
    .XLEN(32),
    .AW  (5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .clear_req(clear_req),
    .busy     (busy),
`ifdef RFARB_FWD_EN
    .fwd_a1   (fwd_a1),
    .fwd_a2   (fwd_a2),
    .fwd_hit1 (fwd_hit1),
    .fwd_hit2 (fwd_hit2),
    .fwd_data (fwd_data),
`endif
    .rf_a3    (rf_a3),
    .rf_wd3   (rf_wd3),
    .rf_we3   (rf_we3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic        chk_ad;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd3;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                              input logic [2:0] r, input logic we, input logic ca,
                              input logic [4:0] a3, input logic [31:0] wd);
    vec_t t;
    t.valid = v; t.addr = a; t.data = d; t.exp_ready = r;
    t.exp_we = we; t.chk_ad = ca; t.exp_a3 = a3; t.exp_wd3 = wd;
    return t;
  endfunction

  // One ARB-state cycle: drive, check the combinational grant, then the registered write.
  task automatic apply(input string tag, input vec_t t);
    @(negedge clk);
    req_valid = t.valid; req_addr = t.addr; req_data = t.data; clear_req = 1'b0;
    #1;
    chk({tag, " ready"}, req_ready, t.exp_ready);
    chk({tag, " busy"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, " we3"}, rf_we3, t.exp_we);
    if (t.chk_ad) begin
      chk({tag, " a3"}, rf_a3, t.exp_a3);
      chk({tag, " wd3"}, rf_wd3, t.exp_wd3);
    end
  endtask

  task automatic sweep(input string tag, input int nsteps, input int clr_at);
    for (int k = 1; k <= nsteps; k++) begin
      @(negedge clk);
      clear_req = (k == clr_at);
      #1;
      chk({tag, " busy"}, busy, 1);
      chk({tag, " ready"}, req_ready, 0);
      @(posedge clk); #1;
      chk({tag, " we3"}, rf_we3, 1);
      chk({tag, " a3"}, rf_a3, k);
      chk({tag, " wd3"}, rf_wd3, 0);
    end
    clear_req = 1'b0;
  endtask

  // Reference model state for the randomized phase.
  int          m_busy, m_pos, m_ptr;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  logic        m_we;

  function automatic int pick(input logic [2:0] v, input int ptr);
    int j;
    for (int k = 0; k < 3; k++) begin
      j = (ptr + k) % 3;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  initial begin
    logic [2:0]  rv;
    logic [14:0] ra;
    logic [95:0] rd;
    logic        rc;
    logic [2:0]  exp_r;
    int          g;

    reset_n = 1'b0; req_valid = 3'b111; req_addr = '0; req_data = '0; clear_req = 1'b0;
`ifdef RFARB_FWD_EN
    fwd_a1 = '0; fwd_a2 = '0;
`endif

    tbl[0]  = mk(3'b000, {5'd7, 5'd6, 5'd5}, {DC, DB, DA}, 3'b000, 0, 1, 5'd31, 32'h0);
    tbl[1]  = mk(3'b111, {5'd7, 5'd6, 5'd5}, {DC, DB, DA}, 3'b001, 1, 1, 5'd5, DA);
    tbl[2]  = mk(3'b111, {5'd7, 5'd6, 5'd5}, {DC, DB, DA}, 3'b010, 1, 1, 5'd6, DB);
    tbl[3]  = mk(3'b111, {5'd7, 5'd6, 5'd5}, {DC, DB, DA}, 3'b100, 1, 1, 5'd7, DC);
    tbl[4]  = mk(3'b111, {5'd7, 5'd6, 5'd5}, {DC, DB, DA}, 3'b001, 1, 1, 5'd5, DA);
    tbl[5]  = mk(3'b000, {5'd7, 5'd6, 5'd5}, {DC, DB, DA}, 3'b000, 0, 1, 5'd5, DA);
    tbl[6]  = mk(3'b101, {5'd7, 5'd6, 5'd5}, {DC, DB, DA}, 3'b100, 1, 1, 5'd7, DC);
    tbl[7]  = mk(3'b001, {5'd7, 5'd6, 5'd0}, {DC, DB, 32'hDEAD}, 3'b001, 0, 0, 5'd0, 32'h0);
    tbl[8]  = mk(3'b011, {5'd7, 5'd6, 5'd5}, {DC, DB, DA}, 3'b010, 1, 1, 5'd6, DB);
    tbl[9]  = mk(3'b011, {5'd7, 5'd6, 5'd5}, {DC, DB, DA}, 3'b001, 1, 1, 5'd5, DA);
    tbl[10] = mk(3'b011, {5'd7, 5'd9, 5'd9}, {DC, 32'h222, 32'h111}, 3'b010, 1, 1, 5'd9, 32'h222);
    tbl[11] = mk(3'b011, {5'd7, 5'd9, 5'd9}, {DC, 32'h222, 32'h111}, 3'b001, 1, 1, 5'd9, 32'h111);
    tbl[12] = mk(3'b000, {5'd7, 5'd9, 5'd9}, {DC, 32'h222, 32'h111}, 3'b000, 0, 1, 5'd9, 32'h111);

    // Reset values, with requests pending to show ready stays low.
    repeat (2) @(negedge clk);
    #1;
    chk("rst we3", rf_we3, 0);
    chk("rst a3", rf_a3, 0);
    chk("rst wd3", rf_wd3, 0);
    chk("rst busy", busy, 1);
    chk("rst ready", req_ready, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    req_valid = 3'b000;
    sweep("init", 31, -1);

    for (int i = 0; i < 13; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // clear_req pre-empts req1, sweep ignores a second pulse, then req1 is served.
    @(negedge clk);
    req_valid = 3'b010; req_addr = {5'd7, 5'd6, 5'd5}; req_data = {DC, DB, DA}; clear_req = 1'b1;
    #1;
    chk("clr ready", req_ready, 0);
    chk("clr busy pre", busy, 0);
    @(posedge clk); #1;
    chk("clr we3", rf_we3, 0);
    chk("clr busy post", busy, 1);
    sweep("clr", 31, 15);
    apply("post clr", mk(3'b010, {5'd7, 5'd6, 5'd5}, {DC, DB, DA}, 3'b010, 1, 1, 5'd6, DB));

    // Pointer now at 2, so req0 wins.
    apply("fwd wr", mk(3'b001, {5'd7, 5'd6, 5'd9}, {DC, DB, 32'h1234}, 3'b001, 1, 1, 5'd9,
                       32'h1234));
`ifdef RFARB_FWD_EN
    fwd_a1 = 5'd9; fwd_a2 = 5'd0;
    #1;
    chk("fwd hit1", fwd_hit1, 1);
    chk("fwd data", fwd_data, 32'h1234);
    chk("fwd hit2", fwd_hit2, 0);
    fwd_a1 = '0;
`endif

    // Reset part-way through a clear sweep restarts from x1.
    @(negedge clk);
    req_valid = 3'b000; clear_req = 1'b1;
    @(posedge clk); #1;
    sweep("pre rst", 10, -1);
    reset_n = 1'b0;
    #1;
    chk("mid rst we3", rf_we3, 0);
    chk("mid rst a3", rf_a3, 0);
    chk("mid rst busy", busy, 1);
    #1;
    reset_n = 1'b1;
    sweep("re init", 31, -1);

    m_busy = 0; m_pos = 1; m_ptr = 0; m_a3 = 5'd31; m_wd3 = '0; m_we = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rv = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        ra[i*5 +: 5]   = 5'($urandom_range(0, 31));
        rd[i*32 +: 32] = $urandom;
      end
      rc = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      req_valid = rv; req_addr = ra; req_data = rd; clear_req = rc;
      g = pick(rv, m_ptr);
      exp_r = '0;
      if (!m_busy && !rc && g >= 0) exp_r[g] = 1'b1;
      #1;
      chk("rnd ready", req_ready, exp_r);
      chk("rnd busy", busy, m_busy);
      if (m_busy) begin
        m_a3 = 5'(m_pos); m_wd3 = '0; m_we = 1'b1;
        if (m_pos == 31) begin m_busy = 0; m_pos = 1; end
        else m_pos++;
      end else if (rc) begin
        m_busy = 1; m_we = 1'b0;
      end else if (g >= 0) begin
        m_a3 = ra[g*5 +: 5]; m_wd3 = rd[g*32 +: 32]; m_we = (m_a3 != 0);
        m_ptr = (g + 1) % 3;
      end else begin
        m_we = 1'b0;
      end
      @(posedge clk); #1;
      chk("rnd we3", rf_we3, m_we);
      if (m_we) begin
        chk("rnd a3", rf_a3, m_a3);
        chk("rnd wd3", rf_wd3, m_wd3);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
